// File: rtl/clk_div_bank_pkg.sv
// Shared constants for the clock divider bank: default counter width,
// the divisor value that switches a channel off, and common divisors.
package clk_div_bank_pkg;

  localparam int CNT_W_DEF = 16;

  localparam int DIV_OFF = 0;

  // Half-period giving a 25 MHz VGA pixel clock from a 50 MHz mclk.
  localparam int DIV_VGA_25M = 1;

endpackage : clk_div_bank_pkg

// File: rtl/clk_div_chan.sv
// One divider channel: half-period counter, square-wave output, rising-edge
// strobe and a pending divisor that is only adopted at a terminal count.
module clk_div_chan
  import clk_div_bank_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = 1
) (
  input  logic             mclk,
  input  logic             rst,
  input  logic             sync,
  input  logic             we_hit,
  input  logic [CNT_W-1:0] val,
  output logic             out,
  output logic             rise_stb,
  output logic             pending
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] active_div;
  logic [CNT_W-1:0] pend_div;
  logic             running;
  logic             terminal;
  logic             apply_off;

  assign running   = (active_div != CNT_W'(DIV_OFF));
  assign terminal  = running && (cnt == active_div - CNT_W'(1));
  assign apply_off = pending && (pend_div == CNT_W'(DIV_OFF));

  // A write in the same cycle as an application lands after it, so the old
  // pending value is consumed and the new one waits for the next boundary.
  always_ff @(posedge mclk) begin
    if (rst) begin
      cnt        <= '0;
      out        <= 1'b0;
      rise_stb   <= 1'b0;
      active_div <= CNT_W'(DEFAULT_DIV);
      pend_div   <= CNT_W'(DEFAULT_DIV);
      pending    <= 1'b0;
    end else begin
      if (sync) begin
        cnt      <= '0;
        out      <= 1'b0;
        rise_stb <= 1'b0;
        if (pending) begin
          active_div <= pend_div;
          pending    <= 1'b0;
        end
      end else if (!running) begin
        cnt      <= '0;
        out      <= 1'b0;
        rise_stb <= 1'b0;
        if (pending) begin
          active_div <= pend_div;
          pending    <= 1'b0;
        end
      end else if (terminal) begin
        cnt <= '0;
        if (pending) begin
          active_div <= pend_div;
          pending    <= 1'b0;
        end
        // Switching off forces the output low instead of toggling.
        if (apply_off) begin
          out      <= 1'b0;
          rise_stb <= 1'b0;
        end else begin
          out      <= ~out;
          rise_stb <= ~out;
        end
      end else begin
        cnt      <= cnt + CNT_W'(1);
        rise_stb <= 1'b0;
      end

      if (we_hit) begin
        pend_div <= val;
        pending  <= 1'b1;
      end
    end
  end

endmodule : clk_div_chan

// File: rtl/clk_div_bank.sv
// Bank of independently programmable clock dividers sharing mclk, with a
// global sync pulse that restarts every channel in phase.
module clk_div_bank
  import clk_div_bank_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = 1,
  parameter int SEL_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             mclk,
  input  logic             rst,
  input  logic             sync,
  input  logic             div_we,
  input  logic [SEL_W-1:0] div_sel,
  input  logic [CNT_W-1:0] div_val,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  rise_stb,
  output logic [N_CH-1:0]  div_pending
);

  logic [N_CH-1:0] we_hit;

  // Out-of-range selects match no channel and are silently dropped.
  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    assign we_hit[i] = div_we && (div_sel == SEL_W'(i));

    clk_div_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .mclk     (mclk),
      .rst      (rst),
      .sync     (sync),
      .we_hit   (we_hit[i]),
      .val      (div_val),
      .out      (clk_out[i]),
      .rise_stb (rise_stb[i]),
      .pending  (div_pending[i])
    );
  end

endmodule : clk_div_bank

// File: tb/tb_clk_div_bank.sv
// Scoreboard bench for clk_div_bank: a position-in-period reference model
// predicts each cycle's outputs, a separate monitor compares them.
module tb_clk_div_bank;
  import clk_div_bank_pkg::*;

  localparam int N   = 3;
  localparam int CW  = 16;
  localparam int DEF = 1;
  localparam int SW  = 2;

  logic          mclk = 1'b0;
  logic          rst = 1'b1;
  logic          sync = 1'b0;
  logic          div_we = 1'b0;
  logic [SW-1:0] div_sel = '0;
  logic [CW-1:0] div_val = '0;
  logic [N-1:0]  clk_out;
  logic [N-1:0]  rise_stb;
  logic [N-1:0]  div_pending;

  clk_div_bank #(
    .N_CH        (N),
    .CNT_W       (CW),
    .DEFAULT_DIV (DEF)
  ) dut (
    .mclk        (mclk),
    .rst         (rst),
    .sync        (sync),
    .div_we      (div_we),
    .div_sel     (div_sel),
    .div_val     (div_val),
    .clk_out     (clk_out),
    .rise_stb    (rise_stb),
    .div_pending (div_pending)
  );

  always #5 mclk = ~mclk;

  typedef struct packed {
    logic [N-1:0] clk;
    logic [N-1:0] rise;
    logic [N-1:0] pend;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Model state: active half-period, pending value/flag, position in period.
  int m_div[N];
  int m_pend[N];
  int m_flag[N];
  int m_pos[N];

  function automatic logic model_out(input int ch);
    return (m_div[ch] != 0) && (m_pos[ch] >= m_div[ch]);
  endfunction

  task automatic applyStimulus(input logic r, input logic s, input logic we,
                               input int sel, input int val);
    exp_t e;
    logic old_out;
    int   np;
    int   nd;
    @(negedge mclk);
    rst     = r;
    sync    = s;
    div_we  = we;
    div_sel = SW'(sel);
    div_val = CW'(val);
    for (int ch = 0; ch < N; ch++) begin
      old_out = model_out(ch);
      if (r) begin
        m_div[ch] = DEF; m_pend[ch] = DEF; m_flag[ch] = 0; m_pos[ch] = 0;
      end else begin
        if (s) begin
          if (m_flag[ch] != 0) begin m_div[ch] = m_pend[ch]; m_flag[ch] = 0; end
          m_pos[ch] = 0;
        end else if (m_div[ch] == 0) begin
          m_pos[ch] = 0;
          if (m_flag[ch] != 0) begin m_div[ch] = m_pend[ch]; m_flag[ch] = 0; end
        end else begin
          np = (m_pos[ch] + 1) % (2 * m_div[ch]);
          if (m_flag[ch] != 0 && (np == 0 || np == m_div[ch])) begin
            nd = m_pend[ch];
            m_flag[ch] = 0;
            m_pos[ch] = (nd == 0) ? 0 : ((np == m_div[ch]) ? nd : 0);
            m_div[ch] = nd;
          end else begin
            m_pos[ch] = np;
          end
        end
        if (we && sel < N && sel == ch) begin
          m_pend[ch] = val; m_flag[ch] = 1;
        end
      end
      e.clk[ch]  = model_out(ch);
      e.rise[ch] = e.clk[ch] && !old_out;
      e.pend[ch] = (m_flag[ch] != 0);
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic checkOutput(input exp_t e);
    vectors++;
    if (clk_out !== e.clk || rise_stb !== e.rise || div_pending !== e.pend) begin
      miscompares++;
      $display("[TB] FAIL vec%0d clk_out=%b exp=%b rise_stb=%b exp=%b div_pending=%b exp=%b",
               vectors, clk_out, e.clk, rise_stb, e.rise, div_pending, e.pend);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge mclk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin : stimulus
    for (int ch = 0; ch < N; ch++) begin
      m_div[ch] = DEF; m_pend[ch] = DEF; m_flag[ch] = 0; m_pos[ch] = 0;
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
    idle(20);
    applyStimulus(1'b0, 1'b0, 1'b1, 1, 3);
    idle(14);
    applyStimulus(1'b0, 1'b0, 1'b1, 0, 0);
    idle(6);
    applyStimulus(1'b0, 1'b0, 1'b1, 0, 2);
    idle(10);
    applyStimulus(1'b0, 1'b0, 1'b1, 1, 5);
    applyStimulus(1'b0, 1'b0, 1'b1, 1, 7);
    applyStimulus(1'b0, 1'b0, 1'b1, 3, 9);
    idle(32);
    applyStimulus(1'b0, 1'b0, 1'b1, 0, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1, 4);
    idle(20);
    applyStimulus(1'b0, 1'b0, 1'b1, 2, 6);
    applyStimulus(1'b0, 1'b1, 1'b0, 0, 0);
    idle(12);
    applyStimulus(1'b0, 1'b1, 1'b1, 2, 2);
    idle(12);
    applyStimulus(1'b0, 1'b0, 1'b1, 1, 9);
    idle(24);
    applyStimulus(1'b0, 1'b0, 1'b1, 1, 5);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
    idle(6);
    for (int k = 0; k < 3000; k++) begin
      applyStimulus(($urandom % 400) == 0, ($urandom % 50) == 0, ($urandom % 8) == 0,
                    int'($urandom % 4),
                    (($urandom % 8) == 0) ? int'($urandom_range(8, 40))
                                          : int'($urandom_range(0, 6)));
    end
    @(posedge mclk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d expected vectors left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_clk_div_bank
